hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
Pipeline hazard controller for the 5-stage MIPS core. It keeps a shadow copy of each in-flight instruction's destination register, reg-write flag and mem-read flag for the EX, MEM and WB stages. It produces registered ForwardA/ForwardB selects for the EX-stage forwarding muxes, detects load-use hazards and inserts bubbles, and sequences branch flushes. It sits beside the ID/EX pipeline register and drives pipeline write-enables and flush controls.

Parameters:
REG_ADDR_W, 5, register-file address width
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs  in  REG_ADDR_W  source register A of ID instruction
id_rt  in  REG_ADDR_W  source register B of ID instruction
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt (R-type, sw, beq)
id_dest  in  REG_ADDR_W  destination of ID instruction (after RegDst mux)
id_reg_write  in  1  ID instruction writes the register file
id_mem_read  in  1  ID instruction is a load
ex_branch_taken  in  1  branch resolved taken in EX this cycle
ext_stall  in  1  memory-system freeze request
ForwardA  out  2  EX mux A select: 00 regfile, 01 MEM/WB read data, 10 EX/MEM ALU result
ForwardB  out  2  EX mux B select, same encoding
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID register enable
id_ex_bubble  out  1  load zero control into ID/EX
flush_if_id  out  1  clear IF/ID
flush_id_ex  out  1  clear ID/EX

Behaviour:
- Reset (async, active-high): shadow EX/MEM/WB entries cleared (dest=0, reg_write=0, mem_read=0); ForwardA=ForwardB=00. With that state the combinational outputs are pc_write=1, if_id_write=1, and bubble and flush signals 0.
- Register 0 is never a hazard or forwarding source. Any match on dest 0 is ignored.
- Each cycle without freeze, the shadow pipeline advances: WB<=MEM, MEM<=EX, and EX<=ID fields, or a bubble when id_ex_bubble, flush_id_ex or !id_valid.
- Forward selects are computed at the ID->EX transfer and registered, so they are valid for the whole EX cycle. For rs:
  - If EX.reg_write and EX.dest==id_rs, select 10. This entry reaches MEM next cycle.
  - Else if MEM.reg_write and MEM.dest==id_rs, select 01.
  - Else select 00.
  - Newest producer wins. rt uses the same rules. An unused source gives 00.
- The register file is write-through, so WB-to-ID needs no forwarding.
- Load-use hazard:
  - Condition: id_valid, EX.mem_read, EX.dest!=0, and (id_uses_rs and EX.dest==id_rs, or id_uses_rt and EX.dest==id_rt).
  - Response, same cycle: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - Exactly one bubble. Next cycle the load is in MEM, so the held instruction transfers with select 01.
- Branch flush: when ex_branch_taken, flush_if_id=1 and flush_id_ex=1, and the shadow EX receives a bubble. This overrides a simultaneous load-use (pc_write=1).
- ext_stall freezes all shadow state and Forward registers: pc_write=0, if_id_write=0, no bubble, no flush, ex_branch_taken ignored. The datapath holds the branch outcome until the freeze ends.
- Priority: reset > ext_stall > branch flush > load-use > normal advance.
- Reset mid-stall: all state is cleared immediately; any pending bubble or flush is lost.

Optional Feature:
HAZARD_PERF_EN. When defined, adds outputs stall_count and flush_count (CNT_W each):
- Each increments once per cycle of load-use stall or branch flush respectively. Cycles under ext_stall are not counted.
- Both saturate at all-ones and reset to 0.
When not defined, the ports and logic are absent and the behaviour above is unchanged.

Decomposition:
- Shared package: forward select constants FWD_REG=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10; REG_ZERO; a shadow-entry struct {dest, reg_write, mem_read}.
- One sub-module, hazard_stage_reg: a shadow-entry register with enable and synchronous clear, instantiated for EX, MEM and WB.

Test Plan:
- add $3,$1,$2 then sub $4,$3,$5 -> sub's EX cycle has ForwardA=10, ForwardB=00, no stall.
- add $3,.. ; nop ; and $6,$7,$3 -> and's EX cycle has ForwardB=01, ForwardA=00.
- lw $8,0($9) then add $10,$8,$8 -> one cycle pc_write=0, if_id_write=0, id_ex_bubble=1; then add in EX with ForwardA=ForwardB=01.
- add $0,$1,$2 then or $5,$0,$0 -> ForwardA=ForwardB=00, no stall.
- Load-use coinciding with ex_branch_taken=1 -> flush_if_id=flush_id_ex=1, pc_write=1, id_ex_bubble=0. Then ext_stall=1 for 3 cycles mid-hazard -> all shadow/Forward state unchanged, pc_write=0.
- Assert reset during a load-use stall -> next cycle ForwardA=ForwardB=00, pc_write=1, HAZARD_PERF_EN counters=0.

Source files
------------

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// Build option HAZARD_PERF_EN (see hazard_forward_ctrl.sv) does not affect this package.
package hazard_forward_ctrl_pkg;

  localparam int SHADOW_ADDR_W = 5;

  localparam logic [1:0] FWD_REG    = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  localparam logic [SHADOW_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [SHADOW_ADDR_W-1:0] dest;
    logic                     reg_write;
    logic                     mem_read;
  } shadow_entry_t;

  localparam shadow_entry_t SHADOW_EMPTY = '{dest: '0, reg_write: 1'b0, mem_read: 1'b0};

  // Newest producer wins: the EX entry is checked before the MEM entry.
  function automatic logic [1:0] fwd_select(input logic [SHADOW_ADDR_W-1:0] src,
                                            input logic used,
                                            input shadow_entry_t ex,
                                            input shadow_entry_t mem);
    fwd_select = FWD_REG;
    if (used && src != REG_ZERO) begin
      if (ex.reg_write && ex.dest == src)
        fwd_select = FWD_EX_MEM;
      else if (mem.reg_write && mem.dest == src)
        fwd_select = FWD_MEM_WB;
    end
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_stage_reg.sv
// One shadow pipeline entry (dest, reg_write, mem_read) with enable and
// synchronous clear; the clear wins over the enable and loads an empty entry.
module hazard_stage_reg
  import hazard_forward_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  input  shadow_entry_t d,
  output shadow_entry_t q
);

  shadow_entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (clr)
      entry_d = SHADOW_EMPTY;
    else if (en)
      entry_d = d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      entry_q <= SHADOW_EMPTY;
    else
      entry_q <= entry_d;
  end

  assign q = entry_q;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard controller for the 5-stage MIPS core: registered forward selects,
// load-use bubbles and branch flushes. Define HAZARD_PERF_EN for stall/flush counters.
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  ext_stall,
  output logic [1:0]            ForwardA,
  output logic [1:0]            ForwardB,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_bubble,
  output logic                  flush_if_id,
  output logic                  flush_id_ex
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
`endif
);

  if (REG_ADDR_W != SHADOW_ADDR_W || CNT_W < 1) begin : g_bad_cfg
    $error("hazard_forward_ctrl: REG_ADDR_W must equal SHADOW_ADDR_W and CNT_W must be positive");
  end

  shadow_entry_t ex_q, mem_q, wb_q, ex_d;
  logic          load_use, advance, ex_clr;
  logic [1:0]    fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  always_comb begin
    load_use = id_valid && ex_q.mem_read && (ex_q.dest != REG_ZERO) &&
               ((id_uses_rs && ex_q.dest == id_rs) || (id_uses_rt && ex_q.dest == id_rt));
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    if (reset) begin
      // outputs stay at their idle values while state is being cleared
    end else if (ext_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (ex_branch_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_comb begin
    advance = !ext_stall;
    ex_clr  = advance && (!id_valid || id_ex_bubble || flush_id_ex);
    ex_d    = '{dest: id_dest, reg_write: id_reg_write, mem_read: id_mem_read};
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    // Selects are fixed at the ID->EX transfer; a bubble entering EX reads the regfile.
    if (advance) begin
      fwd_a_d = ex_clr ? FWD_REG : fwd_select(id_rs, id_uses_rs, ex_q, mem_q);
      fwd_b_d = ex_clr ? FWD_REG : fwd_select(id_rt, id_uses_rt, ex_q, mem_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign ForwardA = fwd_a_q;
  assign ForwardB = fwd_b_q;

  hazard_stage_reg u_ex  (.clk(clk), .reset(reset), .en(advance), .clr(ex_clr), .d(ex_d),  .q(ex_q));
  hazard_stage_reg u_mem (.clk(clk), .reset(reset), .en(advance), .clr(1'b0),   .d(ex_q),  .q(mem_q));
  hazard_stage_reg u_wb  (.clk(clk), .reset(reset), .en(advance), .clr(1'b0),   .d(mem_q), .q(wb_q));

  // The regfile is write-through, so nothing downstream consumes the WB entry.
  logic unused_wb;
  assign unused_wb = ^wb_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_count_q, stall_count_d, flush_count_q, flush_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (id_ex_bubble && stall_count_q != '1)
      stall_count_d = stall_count_q + CNT_W'(1);
    if (flush_id_ex && flush_count_q != '1)
      flush_count_d = flush_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl with an instruction-level reference model.
// Counter checks are active when HAZARD_PERF_EN is defined.
module tb_hazard_forward_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       ex_branch_taken, ext_stall;
  logic [1:0] ForwardA, ForwardB;
  logic       pc_write, if_id_write, id_ex_bubble, flush_if_id, flush_id_ex;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count, flush_count;
`endif

  int total = 0;
  int bad   = 0;

  hazard_forward_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .ext_stall(ext_stall),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex)
`ifdef HAZARD_PERF_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
  logic [4:0]  m_dest [3];
  logic        m_wr   [3];
  logic        m_ld   [3];
  logic [1:0]  m_fa, m_fb;
  logic [31:0] m_sc, m_fc;

  function automatic logic [1:0] exp_fwd(input logic [4:0] r, input logic used);
    if (!used || r == 5'd0) return 2'b00;
    for (int i = 0; i < 2; i++)
      if (m_wr[i] && m_dest[i] == r) return (i == 0) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_load_use();
    return id_valid && m_ld[0] && m_dest[0] != 5'd0 &&
           ((id_uses_rs && id_rs == m_dest[0]) || (id_uses_rt && id_rt == m_dest[0]));
  endfunction

  always @(posedge clk or posedge reset) begin : model
    logic br, lu, bub;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        m_dest[i] <= 5'd0; m_wr[i] <= 1'b0; m_ld[i] <= 1'b0;
      end
      m_fa <= 2'b00; m_fb <= 2'b00; m_sc <= 32'd0; m_fc <= 32'd0;
    end else if (!ext_stall) begin
      br  = ex_branch_taken;
      lu  = !br && exp_load_use();
      bub = !id_valid || br || lu;
      m_fa <= bub ? 2'b00 : exp_fwd(id_rs, id_uses_rs);
      m_fb <= bub ? 2'b00 : exp_fwd(id_rt, id_uses_rt);
      m_dest[2] <= m_dest[1]; m_wr[2] <= m_wr[1]; m_ld[2] <= m_ld[1];
      m_dest[1] <= m_dest[0]; m_wr[1] <= m_wr[0]; m_ld[1] <= m_ld[0];
      m_dest[0] <= bub ? 5'd0 : id_dest;
      m_wr[0]   <= bub ? 1'b0 : id_reg_write;
      m_ld[0]   <= bub ? 1'b0 : id_mem_read;
      if (lu && m_sc != 32'hFFFF_FFFF) m_sc <= m_sc + 32'd1;
      if (br && m_fc != 32'hFFFF_FFFF) m_fc <= m_fc + 32'd1;
    end
  end

  always @(negedge clk) begin : compare
    logic e_pc, e_ifid, e_bub, e_fl;
    e_pc = 1'b1; e_ifid = 1'b1; e_bub = 1'b0; e_fl = 1'b0;
    if (reset) begin
    end else if (ext_stall) begin
      e_pc = 1'b0; e_ifid = 1'b0;
    end else if (ex_branch_taken) begin
      e_fl = 1'b1;
    end else if (exp_load_use()) begin
      e_pc = 1'b0; e_ifid = 1'b0; e_bub = 1'b1;
    end
    chk("cyc_ForwardA", ForwardA, m_fa);
    chk("cyc_ForwardB", ForwardB, m_fb);
    chk("cyc_pc_write", pc_write, e_pc);
    chk("cyc_if_id_write", if_id_write, e_ifid);
    chk("cyc_id_ex_bubble", id_ex_bubble, e_bub);
    chk("cyc_flush_if_id", flush_if_id, e_fl);
    chk("cyc_flush_id_ex", flush_id_ex, e_fl);
`ifdef HAZARD_PERF_EN
    chk("cyc_stall_count", stall_count, m_sc);
    chk("cyc_flush_count", flush_count, m_fc);
`endif
  end

  task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic [4:0] dest,
                     input logic rw, input logic mr, input logic br, input logic st);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_dest = dest; id_reg_write = rw; id_mem_read = mr;
    ex_branch_taken = br; ext_stall = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_ForwardA", ForwardA, 2'b00);
    chk("rst_ForwardB", ForwardB, 2'b00);
    chk("rst_pc_write", pc_write, 1'b1);
    chk("rst_if_id_write", if_id_write, 1'b1);
    chk("rst_bubble", id_ex_bubble, 1'b0);
    chk("rst_flush", {flush_if_id, flush_id_ex}, 2'b00);
    reset = 1'b0;

    // add $3,$1,$2 ; sub $4,$3,$5
    drv(1, 1, 2, 1, 1, 3, 1, 0, 0, 0); tick();
    drv(1, 3, 5, 1, 1, 4, 1, 0, 0, 0); #1;
    chk("exmem_no_stall", pc_write, 1'b1);
    tick();
    chk("exmem_ForwardA", ForwardA, 2'b10);
    chk("exmem_ForwardB", ForwardB, 2'b00);

    // add $3,$1,$2 ; nop ; and $6,$7,$3
    drv(1, 1, 2, 1, 1, 3, 1, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drv(1, 7, 3, 1, 1, 6, 1, 0, 0, 0); tick();
    chk("memwb_ForwardA", ForwardA, 2'b00);
    chk("memwb_ForwardB", ForwardB, 2'b01);

    // lw $8,0($9) ; add $10,$8,$8
    drv(1, 9, 0, 1, 0, 8, 1, 1, 0, 0); tick();
    drv(1, 8, 8, 1, 1, 10, 1, 0, 0, 0); #1;
    chk("lu_pc_write", pc_write, 1'b0);
    chk("lu_if_id_write", if_id_write, 1'b0);
    chk("lu_bubble", id_ex_bubble, 1'b1);
    tick(); #1;
    chk("lu_one_bubble", id_ex_bubble, 1'b0);
    chk("lu_bubble_fwd", ForwardA, 2'b00);
    tick();
    chk("lu_ForwardA", ForwardA, 2'b01);
    chk("lu_ForwardB", ForwardB, 2'b01);

    // add $0,$1,$2 ; or $5,$0,$0
    drv(1, 1, 2, 1, 1, 0, 1, 0, 0, 0); tick();
    drv(1, 0, 0, 1, 1, 5, 1, 0, 0, 0); #1;
    chk("r0_no_stall", id_ex_bubble, 1'b0);
    tick();
    chk("r0_fwd", {ForwardA, ForwardB}, 4'b0000);

    // load-use coinciding with a taken branch
    drv(1, 9, 0, 1, 0, 8, 1, 1, 0, 0); tick();
    drv(1, 8, 8, 1, 1, 10, 1, 0, 1, 0); #1;
    chk("br_flush", {flush_if_id, flush_id_ex}, 2'b11);
    chk("br_pc_write", pc_write, 1'b1);
    chk("br_bubble", id_ex_bubble, 1'b0);
    tick();

    // lw $11,0($8) then add $12,$11,$11 frozen by ext_stall for 3 cycles
    drv(1, 8, 0, 1, 0, 11, 1, 1, 0, 0); #1;
    chk("post_flush_no_stall", id_ex_bubble, 1'b0);
    tick();
    chk("lw11_ForwardA", ForwardA, 2'b01);
    drv(1, 11, 11, 1, 1, 12, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      ex_branch_taken = (i == 1);
      #1;
      chk("frz_pc_write", pc_write, 1'b0);
      chk("frz_no_bubble", id_ex_bubble, 1'b0);
      chk("frz_no_flush", flush_id_ex, 1'b0);
      tick();
      chk("frz_ForwardA", ForwardA, 2'b01);
    end
    ex_branch_taken = 1'b0; ext_stall = 1'b0; #1;
    chk("unfrz_bubble", id_ex_bubble, 1'b1);
    chk("unfrz_pc_write", pc_write, 1'b0);
    tick(); #1;
    chk("unfrz_one_bubble", id_ex_bubble, 1'b0);
    tick();
    chk("unfrz_fwd", {ForwardA, ForwardB}, 4'b0101);

    // reset asserted during a load-use stall
    drv(1, 9, 0, 1, 0, 13, 1, 1, 0, 0); tick();
    drv(1, 13, 2, 1, 1, 14, 1, 0, 0, 0); #1;
    chk("rlu_bubble", id_ex_bubble, 1'b1);
`ifdef HAZARD_PERF_EN
    chk("perf_stall_count", stall_count, 32'd2);
    chk("perf_flush_count", flush_count, 32'd1);
`endif
    #1 reset = 1'b1;
    #1;
    chk("rlu_ForwardA", ForwardA, 2'b00);
    chk("rlu_pc_write", pc_write, 1'b1);
    chk("rlu_no_bubble", id_ex_bubble, 1'b0);
`ifdef HAZARD_PERF_EN
    chk("rlu_stall_count", stall_count, 32'd0);
    chk("rlu_flush_count", flush_count, 32'd0);
`endif
    reset = 1'b0;
    tick();
    chk("after_rst_fwd", {ForwardA, ForwardB}, 4'b0000);
    chk("after_rst_pc_write", pc_write, 1'b1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
